// File: rtl/hring_pkg.sv
// Shared constants for the RC ring local injection path: flit layout and slot state encoding.
package hring_pkg;

  localparam int unsigned FLIT_W    = 144;
  localparam int unsigned FIELD_W   = 4;
  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned SRC_LSB   = 4;
  localparam int unsigned VALID_BIT = 11;
  localparam int unsigned MSHR_LSB  = 12;

  localparam int unsigned AGE_W = 8;
  localparam logic [AGE_W-1:0] AGE_SAT = '1;

  // Low 16 bits of a flit as seen by the router control path.
  typedef struct packed {
    logic [FIELD_W-1:0] mshr;
    logic               valid;
    logic [2:0]         rsvd;
    logic [FIELD_W-1:0] src;
    logic [FIELD_W-1:0] dest;
  } flit_hdr_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_HOLD = 1'b1
  } slot_state_e;

endpackage

// File: rtl/hring_inj_slot.sv
// One injection slot: captures a flit, holds it on its port until acked, and tracks hold age.
module hring_inj_slot #(
  parameter int unsigned FLIT_W     = hring_pkg::FLIT_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              ack_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              busy_o,
  output logic              starve_o
);
  import hring_pkg::*;

  slot_state_e       state_q, state_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              starve_q, starve_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SLOT_IDLE;
      flit_q   <= '0;
      age_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flit_q   <= flit_d;
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  // The flit register is zeroed on ack so an idle port drives an invalid flit.
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    age_d   = age_q;
    case (state_q)
      SLOT_IDLE: begin
        if (cap_i) begin
          state_d           = SLOT_HOLD;
          flit_d            = flit_i;
          flit_d[VALID_BIT] = 1'b1;
          age_d             = AGE_W'(1);
        end
      end
      SLOT_HOLD: begin
        if (ack_i) begin
          state_d = SLOT_IDLE;
          flit_d  = '0;
          age_d   = '0;
        end else if (age_q != AGE_SAT) begin
          age_d = age_q + AGE_W'(1);
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
    starve_d = (state_d == SLOT_HOLD) && (age_d >= AGE_W'(STARVE_MAX));
  end

  assign flit_o   = flit_q;
  assign busy_o   = (state_q == SLOT_HOLD);
  assign starve_o = starve_q;

endmodule

// File: rtl/hring_inject_sched.sv
// Local injection scheduler: round-robin dual grant of NREQ requesters onto the router's two local ports.
module hring_inject_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned FLIT_W     = hring_pkg::FLIT_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  output logic [NREQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]      portl0_ci,
  output logic [FLIT_W-1:0]      portl1_ci,
  input  logic                   portl0_ack,
  input  logic                   portl1_ack,
  output logic [1:0]             slot_busy,
  output logic [1:0]             starve,
  output logic [15:0]            inj_cnt
);
  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] NREQ_X = IDX_W'(NREQ);

  logic [FLIT_W-1:0] flits [NREQ];
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0]  sel0, sel1;
  logic [1:0]        cap;
  logic [1:0]        free;
  logic [1:0]        n_free;
  logic [1:0]        n_gnt;
  logic [IDX_W-1:0]  idx, nxt;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        ack_hit;

  for (genvar i = 0; i < NREQ; i++) begin : g_flit
    assign flits[i] = req_flit[i*FLIT_W +: FLIT_W];
  end

  assign free   = ~slot_busy;
  assign n_free = 2'(free[0]) + 2'(free[1]);

  // Grants depend only on registered slot state, so an ack never reaches req_ready.
  always_comb begin
    req_ready = '0;
    cap       = '0;
    sel0      = '0;
    sel1      = '0;
    rr_d      = rr_q;
    n_gnt     = '0;
    idx       = '0;
    nxt       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + IDX_W'(k);
      if (idx >= NREQ_X) idx = idx - NREQ_X;
      if (rst && req_valid[idx[PTR_W-1:0]] && (n_gnt < n_free)) begin
        req_ready[idx[PTR_W-1:0]] = 1'b1;
        if ((n_gnt == 2'd0) && free[0]) begin
          cap[0] = 1'b1;
          sel0   = idx[PTR_W-1:0];
        end else begin
          cap[1] = 1'b1;
          sel1   = idx[PTR_W-1:0];
        end
        n_gnt = n_gnt + 2'd1;
        nxt   = idx + IDX_W'(1);
        rr_d  = (nxt == NREQ_X) ? '0 : nxt[PTR_W-1:0];
      end
    end
  end

  assign ack_hit = {portl1_ack & slot_busy[1], portl0_ack & slot_busy[0]};
  assign cnt_d   = cnt_q + 16'(ack_hit[0]) + 16'(ack_hit[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign inj_cnt = cnt_q;

  hring_inj_slot #(.FLIT_W(FLIT_W), .STARVE_MAX(STARVE_MAX)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst),
    .cap_i   (cap[0]),
    .flit_i  (flits[sel0]),
    .ack_i   (portl0_ack),
    .flit_o  (portl0_ci),
    .busy_o  (slot_busy[0]),
    .starve_o(starve[0])
  );

  hring_inj_slot #(.FLIT_W(FLIT_W), .STARVE_MAX(STARVE_MAX)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst),
    .cap_i   (cap[1]),
    .flit_i  (flits[sel1]),
    .ack_i   (portl1_ack),
    .flit_o  (portl1_ci),
    .busy_o  (slot_busy[1]),
    .starve_o(starve[1])
  );

endmodule
